softmax_pipe_ctrl: RTL and testbench
====================================

SOFTMAX_PIPE_CTRL -- requirements
Module: softmax_pipe_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 16, Q8.8 signed element width.
REQ-002 SHALL have parameter MAX_LEN, default 64, maximum vector length.
REQ-003 SHALL have parameter LEN_W, default 7, width of length and counters.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-006 SHALL have port start, input, 1, command pulse that begins one vector.
REQ-007 SHALL have port len, input, LEN_W, element count, sampled with start.
REQ-008 SHALL have port busy, output, 1, high in LOAD, ISSUE and DRAIN.
REQ-009 SHALL have port done, output, 1, single-cycle pulse at vector completion.
REQ-010 SHALL have ports s_valid (input, 1), s_data (input, DATA_W) and s_ready (output, 1) as the element input stream.
REQ-011 SHALL have ports pipe_en (output, 1), pipe_valid_in (output, 1), pipe_in_0 (output, DATA_W) and pipe_in_1 (output, DATA_W), which drive en, valid_in, in_0 and in_1 of stage1_log2_approx.
REQ-012 SHALL have ports pipe_valid_out (input, 1) and pipe_log (input, DATA_W), which come from valid_out and log_in_0 of stage1_log2_approx.
REQ-013 SHALL have ports m_valid (output, 1), m_data (output, DATA_W) and m_ready (input, 1) as the result output stream.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, ISSUE, DRAIN and DONE.
REQ-015 IDLE: start with len=0 SHALL be ignored; start with len>0 SHALL latch min(len, MAX_LEN), clear all counters, set max_reg=0x8000 and enter LOAD.
REQ-016 start outside IDLE SHALL be ignored.
REQ-017 LOAD: s_ready=1; each s_valid&s_ready beat SHALL write s_data to buf[ld_idx], increment ld_idx, and update max_reg when signed s_data > max_reg (ties keep the old value).
REQ-018 LOAD SHALL go to ISSUE on the cycle after the beat where ld_idx reaches len−1; s_ready SHALL be 0 in every other state.
REQ-019 ISSUE: pipe_valid_in=pipe_en, pipe_in_0=buf[is_idx], pipe_in_1=max_reg; is_idx SHALL advance only on cycles with pipe_en=1.
REQ-020 ISSUE SHALL go to DRAIN after the issue of is_idx=len−1.
REQ-021 pipe_en SHALL equal m_ready in ISSUE and DRAIN and SHALL be 0 otherwise, so a stalled output freezes the whole pipeline with no loss.
REQ-022 m_valid SHALL equal pipe_valid_out & pipe_en, and m_data SHALL equal pipe_log.
REQ-023 out_cnt SHALL increment on each m_valid&m_ready, in both ISSUE and DRAIN.
REQ-024 DRAIN SHALL go to DONE when out_cnt reaches len.
REQ-025 DONE SHALL assert done=1 for exactly one cycle and then return to IDLE.
REQ-026 pipe_valid_out arriving in IDLE, LOAD or DONE SHALL be dropped and not counted.
REQ-027 Vector latency SHALL be len load beats + len issue cycles + pipeline depth + stall cycles + 1 cycle for DONE.
REQ-028 All counters SHALL be LEN_W wide with no wrap-around; len is saturated to MAX_LEN.

Reset
REQ-029 On rst, the next state SHALL be IDLE, counters 0 and max_reg 0x8000.
REQ-030 On rst, outputs busy, done, s_ready, pipe_en, pipe_valid_in, m_valid SHALL be 0, and pipe_in_0, pipe_in_1 SHALL be 0.
REQ-031 Reset mid-vector SHALL abandon the vector without a done pulse; buf contents are not cleared.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, Q8.8 width constants and the 0x8000 minimum constant.
REQ-033 The element buffer SHALL be one sub-module, softmax_vec_buf: MAX_LEN×DATA_W, one synchronous write port and one combinational read port.
REQ-034 The controller SHALL NOT instantiate stage1_log2_approx; it connects externally.

Verification
REQ-035 len=4, inputs 0x0100, 0x0300, 0x0200, 0x0080, m_ready=1 -> four issues, each with pipe_in_1=0x0300, four m_valid beats in order, then one done pulse.
REQ-036 len=3, m_ready low for 5 cycles mid-ISSUE -> pipe_en=0 for those cycles, is_idx holds, exactly 3 outputs, no duplicates or drops.
REQ-037 Negative inputs 0xFF00, 0xFE00 -> max_reg=0xFF00; len=0 start -> stays IDLE, busy=0.
REQ-038 Start during busy -> ignored; len=100 -> exactly 64 load beats accepted.
REQ-039 rst asserted in DRAIN -> IDLE next cycle, no done pulse; a new start with len=1 then completes normally.

Source files
------------

// File: rtl/softmax_pipe_ctrl_pkg.sv
// Shared types and constants for the softmax pipeline controller.
// Elements are Q8.8 signed fixed point.
package softmax_pipe_ctrl_pkg;

  localparam int Q8_8_W    = 16;
  localparam int Q8_8_FRAC = 8;
  localparam logic [Q8_8_W-1:0] Q8_8_MIN = 16'h8000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/softmax_vec_buf.sv
// Element buffer: one synchronous write port, one combinational read port.
// No reset; contents survive a controller reset.
module softmax_vec_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 64,
  parameter int AW     = 6
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/softmax_pipe_ctrl.sv
// Softmax front-end controller: buffers a vector, finds its max and streams
// (x, max) pairs through an external log2 stage, back-pressured by m_ready.
import softmax_pipe_ctrl_pkg::*;

module softmax_pipe_ctrl #(
  parameter int DATA_W  = Q8_8_W,
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              pipe_en,
  output logic              pipe_valid_in,
  output logic [DATA_W-1:0] pipe_in_0,
  output logic [DATA_W-1:0] pipe_in_1,
  input  logic              pipe_valid_out,
  input  logic [DATA_W-1:0] pipe_log,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  input  logic              m_ready
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [DATA_W-1:0] L_MIN = DATA_W'(Q8_8_MIN);
  localparam logic [LEN_W-1:0]  L_MAX = LEN_W'(MAX_LEN);

  state_t r_state;
  state_t w_next;

  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_ld_idx;
  logic [LEN_W-1:0]  r_is_idx;
  logic [LEN_W-1:0]  r_out_cnt;
  logic [DATA_W-1:0] r_max;

  logic [LEN_W-1:0]  w_len_sat;
  logic [LEN_W-1:0]  w_len_m1;
  logic [LEN_W-1:0]  w_out_nxt;
  logic [DATA_W-1:0] w_rd;
  logic              w_start_ok;
  logic              w_ld_beat;
  logic              w_is_beat;
  logic              w_out_beat;

  assign w_start_ok = start && (len != '0);
  assign w_len_sat  = (len > L_MAX) ? L_MAX : len;
  assign w_len_m1   = r_len - 1'b1;
  assign w_ld_beat  = s_valid && s_ready;
  assign w_is_beat  = pipe_valid_in;
  assign w_out_beat = m_valid && m_ready;
  assign w_out_nxt  = (w_out_beat && (r_out_cnt != r_len)) ?
                      r_out_cnt + 1'b1 : r_out_cnt;

  assign m_valid = pipe_valid_out && pipe_en;
  assign m_data  = pipe_log;

  softmax_vec_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_LEN),
    .AW     (AW)
  ) u_buf (
    .clk     (clk),
    .i_we    (w_ld_beat),
    .i_waddr (r_ld_idx[AW-1:0]),
    .i_wdata (s_data),
    .i_raddr (r_is_idx[AW-1:0]),
    .o_rdata (w_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_start_ok) w_next = ST_LOAD;
      ST_LOAD:  if (w_ld_beat && r_ld_idx == w_len_m1) w_next = ST_ISSUE;
      ST_ISSUE: if (w_is_beat && r_is_idx == w_len_m1) w_next = ST_DRAIN;
      ST_DRAIN: if (w_out_nxt == r_len) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    s_ready       = 1'b0;
    pipe_en       = 1'b0;
    pipe_valid_in = 1'b0;
    pipe_in_0     = '0;
    pipe_in_1     = '0;
    // Outputs are forced quiet for the whole cycle rst is high.
    if (!rst) begin
      unique case (r_state)
        ST_LOAD: begin
          busy    = 1'b1;
          s_ready = 1'b1;
        end
        ST_ISSUE: begin
          busy          = 1'b1;
          pipe_en       = m_ready;
          pipe_valid_in = m_ready;
          pipe_in_0     = w_rd;
          pipe_in_1     = r_max;
        end
        ST_DRAIN: begin
          busy    = 1'b1;
          pipe_en = m_ready;
        end
        ST_DONE: done = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_len     <= '0;
      r_ld_idx  <= '0;
      r_is_idx  <= '0;
      r_out_cnt <= '0;
      r_max     <= L_MIN;
    end else if (r_state == ST_IDLE) begin
      if (w_start_ok) begin
        r_len     <= w_len_sat;
        r_ld_idx  <= '0;
        r_is_idx  <= '0;
        r_out_cnt <= '0;
        r_max     <= L_MIN;
      end
    end else begin
      if (w_ld_beat) begin
        r_ld_idx <= r_ld_idx + 1'b1;
        if ($signed(s_data) > $signed(r_max)) r_max <= s_data;
      end
      if (w_is_beat) r_is_idx <= r_is_idx + 1'b1;
      r_out_cnt <= w_out_nxt;
    end
  end

endmodule

// File: tb/tb_softmax_pipe_ctrl.sv
// Scoreboard bench for softmax_pipe_ctrl with a 3-deep enable-gated
// stand-in for the log2 stage that outputs in_0 - in_1.
module tb_softmax_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [6:0]  len_i;
  logic        busy;
  logic        done;
  logic        s_valid;
  logic [15:0] s_data;
  logic        s_ready;
  logic        pipe_en;
  logic        pipe_valid_in;
  logic [15:0] pipe_in_0;
  logic [15:0] pipe_in_1;
  logic        pipe_valid_out;
  logic [15:0] pipe_log;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  logic [15:0] exp_max;
  logic [15:0] sb [$];

  logic [2:0]  pv;
  logic [15:0] pd [3];

  always #5 clk = ~clk;

  softmax_pipe_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .len            (len_i),
    .busy           (busy),
    .done           (done),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .pipe_en        (pipe_en),
    .pipe_valid_in  (pipe_valid_in),
    .pipe_in_0      (pipe_in_0),
    .pipe_in_1      (pipe_in_1),
    .pipe_valid_out (pipe_valid_out),
    .pipe_log       (pipe_log),
    .m_valid        (m_valid),
    .m_data         (m_data),
    .m_ready        (m_ready)
  );

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else if (pipe_en) begin
      pv    <= {pv[1:0], pipe_valid_in};
      pd[0] <= pipe_in_0 - pipe_in_1;
      pd[1] <= pd[0];
      pd[2] <= pd[1];
    end
  end
  assign pipe_valid_out = pv[2];
  assign pipe_log       = pd[2];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst) begin
      if (m_valid && m_ready) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL out_extra: got %h required none", m_data);
        end else begin
          e = sb.pop_front();
          chk("m_data", {16'h0, m_data}, {16'h0, e});
        end
      end
      if (pipe_valid_in && pipe_en)
        chk("pipe_in_1", {16'h0, pipe_in_1}, {16'h0, exp_max});
      if (done) done_cnt++;
    end
  end

  task automatic go(input logic [6:0] n);
    start = 1'b1;
    len_i = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic [15:0] e);
    logic acc;
    s_valid = 1'b1;
    s_data  = d;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      if (acc) begin
        sb.push_back(e);
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) begin
        @(negedge clk);
        chk({nm, "_done_width"}, {31'h0, done}, 32'd0);
        chk({nm, "_busy_after"}, {31'h0, busy}, 32'd0);
        chk({nm, "_sb_empty"}, sb.size(), 32'd0);
        return;
      end
    end
    chk({nm, "_done_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int beats;
    int n;
    logic acc;
    rst = 1'b1; start = 1'b0; len_i = '0;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b1; exp_max = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out", {busy, done, s_ready, pipe_en, pipe_valid_in, m_valid},
        32'd0);
    chk("rst_pipe_in", {pipe_in_0, pipe_in_1}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic vector
    exp_max = 16'h0300;
    go(7'd4);
    send(16'h0100, 16'hFE00);
    send(16'h0300, 16'h0000);
    send(16'h0200, 16'hFF00);
    send(16'h0080, 16'hFD80);
    wait_done("t1");

    // stall in the middle of ISSUE
    exp_max = 16'h0020;
    go(7'd3);
    send(16'h0010, 16'hFFF0);
    send(16'h0020, 16'h0000);
    send(16'h0005, 16'hFFE5);
    n = 0;
    for (int k = 0; k < 20 && n == 0; k++) begin
      @(negedge clk);
      if (pipe_valid_in) n = 1;
    end
    chk("t2_first_issue", n, 32'd1);
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_stall_en", {31'h0, pipe_en}, 32'd0);
      chk("t2_stall_hold", {16'h0, pipe_in_0}, 32'h0020);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait_done("t2");

    // negative inputs, then a zero-length start
    exp_max = 16'hFF00;
    go(7'd2);
    send(16'hFF00, 16'h0000);
    send(16'hFE00, 16'hFF00);
    wait_done("t3");
    go(7'd0);
    repeat (3) begin
      @(negedge clk);
      chk("t3_len0_busy", {31'h0, busy}, 32'd0);
    end

    // saturated length plus a start while busy
    exp_max = 16'h003F;
    go(7'd100);
    s_valid = 1'b1;
    beats = 0;
    for (int c = 0; c < 200; c++) begin
      s_data = 16'(beats);
      if (c == 10) begin
        start = 1'b1;
        len_i = 7'd5;
      end
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      start = 1'b0;
      if (acc) begin
        sb.push_back(16'(beats) - 16'h003F);
        beats++;
      end else if (beats > 0) begin
        break;
      end
    end
    s_valid = 1'b0;
    chk("t4_load_beats", beats, 32'd64);
    wait_done("t4");

    // reset while draining
    exp_max = 16'h0700;
    go(7'd2);
    send(16'h0700, 16'h0000);
    send(16'h0600, 16'hFF00);
    n = 0;
    for (int k = 0; k < 20 && n < 2; k++) begin
      @(negedge clk);
      if (pipe_valid_in && pipe_en) n++;
    end
    chk("t5_issues", n, 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t5_rst_busy", {31'h0, busy}, 32'd0);
    repeat (10) @(negedge clk);
    chk("t5_no_done", done_cnt, 32'd4);
    @(posedge clk); #1;
    exp_max = 16'h0400;
    go(7'd1);
    send(16'h0400, 16'h0000);
    wait_done("t5");

    chk("done_total", done_cnt, 32'd5);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

endmodule
